// File: rtl/mt_pkg.sv
// Shared constants, FSM encoding and partial-product schedule for the
// Mersenne Twister state initializer.
package mt_pkg;

    localparam logic [31:0] MT32_F = 32'd1812433253;
    localparam logic [63:0] MT64_F = 64'd6364136223846793005;
    localparam int          MT32_N = 624;
    localparam int          MT64_N = 312;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mt_state_e;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] j;
    } mt_pair_t;

    // Number of chunk products (i,j) with i+j < k.
    function automatic int mt_pp(input int k);
        return k * (k + 1) / 2;
    endfunction

    // Chunk pair issued at a given phase: i ascending, then j ascending.
    function automatic mt_pair_t mt_pair(input int ph, input int k);
        mt_pair_t r;
        int       n;
        r = '0;
        n = 0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k - i; j++) begin
                if (n == ph) begin
                    r.i = 8'(i);
                    r.j = 8'(j);
                end
                n++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mt_init_param_if.sv
// Start/seed request and state-RAM write port of the MT initializer.
interface mt_init_param_if #(
    parameter int W  = 32,
    parameter int AW = 10
) ();
    logic          init;
    logic [W-1:0]  seed;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;

    modport master (output init, seed, input waddr, wen, wdata, busy, done);
    modport slave  (input init, seed, output waddr, wen, wdata, busy, done);
endinterface

// File: rtl/mt_init_mac.sv
// Time-multiplexed CW x CW multiplier with W-bit shift-accumulate; computes
// F*(x ^ (x >> (W-2))) + pre mod 2^W over mt_pp(W/CW) phases.
module mt_init_mac
    import mt_pkg::*;
#(
    parameter int           W  = 32,
    parameter int           CW = 16,
    parameter int           PW = 3,
    parameter logic [W-1:0] F  = W'(MT32_F)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] i_ph,
    input  logic [W-1:0]  i_x,
    input  logic [W-1:0]  i_pre,
    output logic [W-1:0]  o_sum
);
    localparam int K = W / CW;

    logic [W-1:0]    w_t;
    mt_pair_t        w_pr;
    logic [CW-1:0]   w_ti;
    logic [CW-1:0]   w_fj;
    logic [2*CW-1:0] r_prod;
    logic [7:0]      r_sh;
    logic [W-1:0]    r_acc;

    assign w_t  = i_x ^ (i_x >> (W - 2));
    assign w_pr = mt_pair(int'(i_ph), K);
    assign w_ti = CW'(w_t >> (CW * int'(w_pr.i)));
    assign w_fj = CW'(F >> (CW * int'(w_pr.j)));

    // Phase 0 preloads the word index; later phases add the previous product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod <= '0;
            r_sh   <= '0;
            r_acc  <= '0;
        end else begin
            r_prod <= {{CW{1'b0}}, w_ti} * {{CW{1'b0}}, w_fj};
            r_sh   <= w_pr.i + w_pr.j;
            r_acc  <= (i_ph == '0) ? i_pre : o_sum;
        end
    end

    // Bits shifted past W are dropped: the sum wraps mod 2^W.
    assign o_sum = r_acc + W'({{W{1'b0}}, r_prod} << (CW * int'(r_sh)));

endmodule

// File: rtl/mt_init_param.sv
// Mersenne Twister state initializer: writes x[0]=seed and
// x[i]=F*(x[i-1]^(x[i-1]>>(W-2)))+i into the state RAM, one word per P cycles.
module mt_init_param
    import mt_pkg::*;
#(
    parameter int           W  = 32,
    parameter int           N  = MT32_N,
    parameter logic [W-1:0] F  = (W == 64) ? W'(MT64_F) : W'(MT32_F),
    parameter int           CW = 16,
    parameter int           AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    mt_init_param_if.slave bus
);
    localparam int            K    = W / CW;
    localparam int            P    = mt_pp(K) + 1;
    localparam int            PW   = $clog2(P) + 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    mt_state_e     r_state;
    mt_state_e     w_nxt;
    logic [PW-1:0] r_ph;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_waddr;
    logic          r_wen;
    logic [W-1:0]  r_wdata;
    logic [W-1:0]  w_sum;
    logic          w_last;
    logic          w_busy;
    logic          w_done;

    // True in the cycle that writes word N-1.
    assign w_last = r_wen && (r_waddr == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (bus.init) begin
            w_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_nxt = ST_IDLE;
                ST_RUN:  if (w_last) w_nxt = ST_DONE;
                ST_DONE: w_nxt = ST_IDLE;
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    // init always wins, restarting the sequence from the new seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph    <= '0;
            r_k     <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wen <= 1'b0;
            if (bus.init) begin
                r_ph    <= '0;
                r_k     <= (N > 1) ? AW'(1) : '0;
                r_waddr <= '0;
                r_wen   <= 1'b1;
                r_wdata <= bus.seed;
            end else if (r_state == ST_RUN && !w_last) begin
                if (r_ph == PW'(P - 1)) begin
                    r_ph    <= '0;
                    r_waddr <= r_k;
                    r_wen   <= 1'b1;
                    r_wdata <= w_sum;
                    if (r_k != LAST) r_k <= r_k + AW'(1);
                end else begin
                    r_ph <= r_ph + PW'(1);
                end
            end
        end
    end

    mt_init_mac #(
        .W  (W),
        .CW (CW),
        .PW (PW),
        .F  (F)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .i_ph  (r_ph),
        .i_x   (r_wdata),
        .i_pre (W'(r_k)),
        .o_sum (w_sum)
    );

    assign bus.waddr = r_waddr;
    assign bus.wen   = r_wen;
    assign bus.wdata = r_wdata;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;

endmodule

// File: tb/tb_mt_init_param.sv
// Directed bench for mt_init_param: MT32, MT64 and N=1 instances.
module tb_mt_init_param;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    logic        s_wen;
    logic [63:0] s_waddr;
    logic [63:0] s_wdata;
    logic        s_busy;
    logic        s_done;
    logic [63:0] cap_w1;
    logic [63:0] exp_w [0:623];
    logic [63:0] seeds [0:3];

    mt_init_param_if #(.W(32), .AW(10)) b32 ();
    mt_init_param_if #(.W(64), .AW(9))  b64 ();
    mt_init_param_if #(.W(32), .AW(1))  b1 ();

    mt_init_param #(.W(32), .N(624), .F(32'd1812433253), .CW(16), .AW(10)) u32 (
        .clk(clk), .reset(reset), .bus(b32));
    mt_init_param #(.W(64), .N(312), .F(64'd6364136223846793005), .CW(16), .AW(9)) u64 (
        .clk(clk), .reset(reset), .bus(b64));
    mt_init_param #(.W(32), .N(1), .F(32'd1812433253), .CW(16), .AW(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl(input logic [63:0] x, input int k, input bit w64);
        logic [63:0] t;
        logic [31:0] t32;
        if (w64) begin
            t = x ^ (x >> 62);
            return t * 64'd6364136223846793005 + 64'(k);
        end
        t32 = x[31:0] ^ (x[31:0] >> 30);
        return {32'd0, t32 * 32'd1812433253 + 32'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input int sel);
        case (sel)
            0: begin
                s_wen = b32.wen; s_waddr = 64'(b32.waddr); s_wdata = 64'(b32.wdata);
                s_busy = b32.busy; s_done = b32.done;
            end
            1: begin
                s_wen = b64.wen; s_waddr = 64'(b64.waddr); s_wdata = b64.wdata;
                s_busy = b64.busy; s_done = b64.done;
            end
            default: begin
                s_wen = b1.wen; s_waddr = 64'(b1.waddr); s_wdata = 64'(b1.wdata);
                s_busy = b1.busy; s_done = b1.done;
            end
        endcase
    endtask

    task automatic start(input int sel, input logic [63:0] seed);
        case (sel)
            0:       begin b32.seed = seed[31:0]; b32.init = 1'b1; end
            1:       begin b64.seed = seed;       b64.init = 1'b1; end
            default: begin b1.seed = seed[31:0];  b1.init = 1'b1; end
        endcase
        step();
        b32.init = 1'b0;
        b64.init = 1'b0;
        b1.init  = 1'b0;
    endtask

    // Called at cycle 1 of a run (init sampled one edge earlier).
    task automatic watch(input int sel, input bit w64, input int n, input int p,
                         input logic [63:0] seed);
        int t_end, nwen, wenbad, busybad, ndone, donecyc, lastcyc, k;
        exp_w[0] = seed;
        for (int i = 1; i < n; i++) exp_w[i] = mdl(exp_w[i-1], i, w64);
        t_end = 1 + (n - 1) * p;
        nwen = 0; wenbad = 0; busybad = 0; ndone = 0; donecyc = -1; lastcyc = -1;
        for (int c = 1; c <= t_end + 2; c++) begin
            samp(sel);
            if (c == 1 + p) cap_w1 = s_wdata;
            if (s_wen !== (((c - 1) % p == 0) && (c <= t_end))) wenbad++;
            if (s_busy !== (c <= t_end)) busybad++;
            if (s_done === 1'b1) begin
                ndone++;
                if (donecyc < 0) donecyc = c;
            end
            if (s_wen === 1'b1) begin
                nwen++;
                lastcyc = c;
                k = (c - 1) / p;
                if (k < n) begin
                    chk("waddr", s_waddr, 64'(k));
                    chk("wdata", s_wdata, exp_w[k]);
                end
            end
            step();
        end
        chk("wen_count", 64'(nwen), 64'(n));
        chk("wen_timing_errs", 64'(wenbad), 64'd0);
        chk("busy_errs", 64'(busybad), 64'd0);
        chk("done_count", 64'(ndone), 64'd1);
        chk("done_cycle", 64'(donecyc), 64'(t_end + 1));
        chk("last_wen_cycle", 64'(lastcyc), 64'(t_end));
    endtask

    initial begin
        int cnt_wen, cnt_done;
        n_chk = 0;
        n_err = 0;
        cap_w1 = '0;
        seeds[0] = 64'd0; seeds[1] = 64'd1; seeds[2] = 64'd5489; seeds[3] = 64'hFFFF_FFFF;
        b32.init = 1'b0; b32.seed = '0;
        b64.init = 1'b0; b64.seed = '0;
        b1.init  = 1'b0; b1.seed  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        samp(0);
        chk("rst_wen", 64'(s_wen), 64'd0);
        chk("rst_waddr", s_waddr, 64'd0);
        chk("rst_wdata", s_wdata, 64'd0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_done", 64'(s_done), 64'd0);
        reset = 1'b0;
        step();

        // MT32 reference seed, then the remaining seeds.
        start(0, 64'd5489);
        watch(0, 1'b0, 624, 4, 64'd5489);
        chk("mt32_w1_5489", cap_w1, 64'd1301868182);
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                start(0, seeds[s]);
                watch(0, 1'b0, 624, 4, seeds[s]);
            end
        end

        // MT64, four chunks -> 11 cycles per word.
        for (int s = 0; s < 4; s++) begin
            start(1, seeds[s]);
            watch(1, 1'b1, 312, 11, seeds[s]);
            if (s == 1) chk("mt64_w1_seed1", cap_w1, 64'd6364136223846793006);
        end

        // Restart at cycle 100 with seed 42.
        start(0, 64'd5489);
        cnt_done = 0;
        for (int c = 1; c < 100; c++) begin
            samp(0);
            if (s_done === 1'b1) cnt_done++;
            step();
        end
        start(0, 64'd42);
        chk("abort_no_done", 64'(cnt_done), 64'd0);
        watch(0, 1'b0, 624, 4, 64'd42);

        // Reset at cycle 50 for three cycles.
        start(0, 64'd5489);
        repeat (49) step();
        reset = 1'b1;
        #1;
        samp(0);
        chk("midrst_wen", 64'(s_wen), 64'd0);
        chk("midrst_waddr", s_waddr, 64'd0);
        chk("midrst_wdata", s_wdata, 64'd0);
        chk("midrst_busy", 64'(s_busy), 64'd0);
        chk("midrst_done", 64'(s_done), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        cnt_wen = 0;
        cnt_done = 0;
        for (int c = 0; c < 20; c++) begin
            samp(0);
            if (s_wen === 1'b1) cnt_wen++;
            if (s_done === 1'b1) cnt_done++;
            step();
        end
        chk("postrst_wen", 64'(cnt_wen), 64'd0);
        chk("postrst_done", 64'(cnt_done), 64'd0);
        start(0, 64'd5489);
        watch(0, 1'b0, 624, 4, 64'd5489);

        // N=1: single write at cycle 1, done at cycle 2.
        start(2, 64'd7);
        watch(2, 1'b0, 1, 4, 64'd7);

        // init coinciding with the done pulse.
        start(2, 64'd11);
        samp(2);
        chk("n1_w0_wen", 64'(s_wen), 64'd1);
        chk("n1_w0_data", s_wdata, 64'd11);
        step();
        samp(2);
        chk("n1_done_with_init", 64'(s_done), 64'd1);
        start(2, 64'd13);
        samp(2);
        chk("n1_restart_wen", 64'(s_wen), 64'd1);
        chk("n1_restart_data", s_wdata, 64'd13);
        chk("n1_restart_busy", 64'(s_busy), 64'd1);
        step();
        samp(2);
        chk("n1_restart_done", 64'(s_done), 64'd1);
        step();
        samp(2);
        chk("n1_idle_done", 64'(s_done), 64'd0);
        chk("n1_idle_busy", 64'(s_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
